// File: rtl/fir_tap_sequencer.sv
// FIR sequencer: weight/window store, skewed wavefront launch into a saturating MAC chain, credit-guarded output FIFO.
// Latency TAPS+1 cycles accept-to-output; s_ready drops only when FIFO_DEPTH results are reserved.

// One saturating MAC stage: y_out <= clamp(y_in + x_in*w_in), 1 cycle, no backpressure.
module fir_mac_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] x_in,
  input  logic [16:0] w_in,
  input  logic [16:0] y_in,
  output logic [16:0] y_out
);
  logic signed [33:0] prod;
  logic signed [34:0] sum;
  logic [16:0] y_d, y_q;

  always_comb begin
    prod = $signed(x_in) * $signed(w_in);
    sum  = {prod[33], prod} + {{18{y_in[16]}}, y_in};
    if (sum > 35'sd65535)       y_d = 17'h0FFFF;
    else if (sum < -35'sd65536) y_d = 17'h10000;
    else                        y_d = sum[16:0];
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y_out = y_q;
endmodule

// Generic show-ahead FIFO; 1-cycle write-to-read, writer must respect free space (no wr_rdy).
module fir_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  assign rd_vld = (wr_ptr_q != rd_ptr_q);
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_vld) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_vld && rd_rdy) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

module fir_tap_sequencer #(
  parameter int TAPS       = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [16:0] cfg_wdata,
  output logic        cfg_err,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [16:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [16:0] m_data,
  output logic        m_last,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [16:0]   w_q [TAPS], w_d [TAPS];
  logic [16:0]   win_q [TAPS], win_d [TAPS];
  logic [16:0]   snap_q [TAPS], snap_d [TAPS];
  logic [16:0]   y [TAPS];
  logic [TAPS:0] vld_q, vld_d, last_q, last_d;
  logic [CW-1:0] rsv_q, rsv_d;
  logic          cfg_err_q, cfg_err_d;
  logic          accept, pop, cfg_ok;
  logic [17:0]   fifo_dout;

  // Credits are taken at accept, so the chain never has to stall on a full FIFO.
  assign s_ready = !rst && (rsv_q < CW'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign busy    = (rsv_q != '0);
  assign cfg_err = cfg_err_q;

  always_comb begin
    snap_d[0] = s_data;
    for (int k = 1; k < TAPS; k++) snap_d[k] = win_q[k-1];
    for (int k = 0; k < TAPS; k++) begin
      win_d[k] = win_q[k];
      if (accept) win_d[k] = s_last ? 17'd0 : snap_d[k];
    end
    vld_d  = {vld_q[TAPS-1:0], accept};
    last_d = {last_q[TAPS-1:0], accept && s_last};
    case ({accept, pop})
      2'b10:   rsv_d = rsv_q + CW'(1);
      2'b01:   rsv_d = rsv_q - CW'(1);
      default: rsv_d = rsv_q;
    endcase
    // A same-cycle accept would make busy true at this edge, so the write loses.
    cfg_ok    = cfg_we && !busy && ({1'b0, cfg_addr} < 5'(TAPS)) && !accept;
    cfg_err_d = cfg_we && !cfg_ok;
    for (int k = 0; k < TAPS; k++) begin
      w_d[k] = w_q[k];
      if (cfg_ok && cfg_addr == 4'(k)) w_d[k] = cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        w_q[k]    <= '0;
        win_q[k]  <= '0;
        snap_q[k] <= '0;
      end
      vld_q     <= '0;
      last_q    <= '0;
      rsv_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        w_q[k]    <= w_d[k];
        win_q[k]  <= win_d[k];
        snap_q[k] <= snap_d[k];
      end
      vld_q     <= vld_d;
      last_q    <= last_d;
      rsv_q     <= rsv_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_stage
    logic [16:0] x_k, y_in_k;
    if (k == 0) begin : g_head
      assign x_k    = snap_q[0];
      assign y_in_k = '0;
    end else begin : g_skew
      logic [16:0] dly_q [k];
      logic [16:0] dly_d [k];
      always_comb begin
        dly_d[0] = snap_q[k];
        for (int j = 1; j < k; j++) dly_d[j] = dly_q[j-1];
      end
      always_ff @(posedge clk) begin
        for (int j = 0; j < k; j++) dly_q[j] <= rst ? 17'd0 : dly_d[j];
      end
      assign x_k    = dly_q[k-1];
      assign y_in_k = y[k-1];
    end
    fir_mac_stage u_mac (
      .clk   (clk),
      .rst   (rst),
      .x_in  (x_k),
      .w_in  (w_q[k]),
      .y_in  (y_in_k),
      .y_out (y[k])
    );
  end

  fir_fifo #(.W(18), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (vld_q[TAPS]),
    .wr_dat ({last_q[TAPS], y[TAPS-1]}),
    .rd_vld (m_valid),
    .rd_rdy (m_ready),
    .rd_dat (fifo_dout)
  );

  assign m_data = fifo_dout[16:0];
  assign m_last = fifo_dout[17];
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer (TAPS=5, FIFO_DEPTH=8) with hand-computed expectations.
module tb_fir_tap_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [16:0] cfg_wdata;
  logic        cfg_err;
  logic        s_valid, s_ready, s_last;
  logic [16:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [16:0] m_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [17:0] got[$];

  fir_tap_sequencer #(.TAPS(5), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got.push_back({m_last, m_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [16:0] d, output logic err);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int c = 0; c < 300 && busy; c++) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drain_timeout busy=%b want 0", busy); end
  endtask

  task automatic set_weights(input logic [16:0] w0, w1, w2, w3, w4);
    logic e;
    drain();
    cfg_write(4'd0, w0, e); cfg_write(4'd1, w1, e); cfg_write(4'd2, w2, e);
    cfg_write(4'd3, w3, e); cfg_write(4'd4, w4, e);
  endtask

  task automatic send(input logic [16:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int c = 0; c < 300 && !s_ready; c++) tick();
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout s_ready=%b want 1", s_ready);
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    for (int c = 0; c < 300 && got.size() < n; c++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b want 0", m_valid); end
    checks++; if (m_data !== 17'd0) begin failures++; $display("FAIL rst_m_data got=%h want 0", m_data); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b want 0", m_last); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%b want 0", cfg_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_rst_s_ready got=%b want 1", s_ready); end
  endtask

  task automatic test_identity();
    logic [17:0] exp [3] = '{{1'b0, 17'd10}, {1'b0, 17'd20}, {1'b1, 17'd30}};
    set_weights(17'd1, 17'd0, 17'd0, 17'd0, 17'd0);
    got.delete(); m_ready = 1'b1;
    send(17'd10, 1'b0); send(17'd20, 1'b0); send(17'd30, 1'b1);
    tick(); tick(); tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL id_latency_early m_valid=%b want 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 17'd10) begin
      failures++; $display("FAIL id_latency_first m_valid=%b m_data=%0d want 1/10", m_valid, m_data);
    end
    wait_outputs(3);
    checks++; if (got.size() != 3) begin failures++; $display("FAIL id_count got=%0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL id_out%0d got=%h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_boxcar();
    logic [17:0] exp [7] = '{{1'b0, 17'd1}, {1'b0, 17'd3}, {1'b0, 17'd6}, {1'b0, 17'd10},
                             {1'b0, 17'd15}, {1'b1, 17'd20}, {1'b1, 17'd7}};
    set_weights(17'd1, 17'd1, 17'd1, 17'd1, 17'd1);
    got.delete(); m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) send(17'(i), i == 6);
    send(17'd7, 1'b1);
    wait_outputs(7);
    checks++; if (got.size() != 7) begin failures++; $display("FAIL box_count got=%0d want 7", got.size()); end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL box_out%0d got=%h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [17:0] exp [6];
    exp[0] = {1'b1, 17'h0FFFF};
    exp[1] = {1'b1, 17'h10000};
    exp[2] = {1'b0, 17'h0FFFF};
    exp[3] = {1'b1, 17'h0FFFF};
    exp[4] = {1'b0, 17'h0FFFF};
    exp[5] = {1'b1, 17'(-24465)};
    got.delete();
    set_weights(17'd300, 17'd0, 17'd0, 17'd0, 17'd0);
    send(17'd300, 1'b1);
    set_weights(17'(-300), 17'd0, 17'd0, 17'd0, 17'd0);
    send(17'd300, 1'b1);
    set_weights(17'd30000, 17'd30000, 17'd0, 17'd0, 17'd0);
    send(17'd3, 1'b0); send(17'd3, 1'b1);
    set_weights(17'd30000, 17'(-30000), 17'd0, 17'd0, 17'd0);
    send(17'd3, 1'b0); send(17'd3, 1'b1);
    wait_outputs(6);
    checks++; if (got.size() != 6) begin failures++; $display("FAIL sat_count got=%0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL sat_out%0d got=%h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    set_weights(17'd1, 17'd0, 17'd0, 17'd0, 17'd0);
    got.delete(); m_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      s_valid = 1'b1; s_data = 17'(100 + acc); s_last = (acc == 19);
      if (s_ready) acc++;
      tick();
    end
    checks++; if (acc != 8) begin failures++; $display("FAIL bp_accepted got=%0d want 8", acc); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready got=%b want 0", s_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b want 1", busy); end
    m_ready = 1'b1;
    for (int c = 0; c < 300 && acc < 20; c++) begin
      s_valid = 1'b1; s_data = 17'(100 + acc); s_last = (acc == 19);
      if (s_ready) acc++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (acc != 20) begin failures++; $display("FAIL bp_total_accepted got=%0d want 20", acc); end
    wait_outputs(20);
    repeat (20) tick();
    checks++; if (got.size() != 20) begin failures++; $display("FAIL bp_count got=%0d want 20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {i == 19, 17'(100 + i)}) begin
        failures++; $display("FAIL bp_out%0d got=%h want %h", i, got[i], {i == 19, 17'(100 + i)});
      end
    end
  endtask

  task automatic test_config_guard();
    logic e;
    set_weights(17'd1, 17'd0, 17'd0, 17'd0, 17'd0);
    m_ready = 1'b0;
    send(17'd5, 1'b1);
    repeat (8) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cg_busy got=%b want 1", busy); end
    cfg_write(4'd2, 17'd77, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL cg_busy_err got=%b want 1", e); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cg_err_one_cycle got=%b want 0", cfg_err); end
    drain();
    cfg_write(4'd7, 17'd9, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL cg_addr_err got=%b want 1", e); end
    s_valid = 1'b1; s_data = 17'd0; s_last = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 17'd55;
    tick();
    s_valid = 1'b0; s_last = 1'b0; cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cg_accept_err got=%b want 1", cfg_err); end
    drain(); got.delete();
    send(17'd5, 1'b0); send(17'd0, 1'b0); send(17'd0, 1'b1);
    wait_outputs(3);
    checks++; if (got.size() != 3) begin failures++; $display("FAIL cg_old_count got=%0d want 3", got.size()); end
    else begin
      checks++; if (got[1] !== {1'b0, 17'd0}) begin failures++; $display("FAIL cg_w1_unchanged got=%h want 0", got[1]); end
      checks++; if (got[2] !== {1'b1, 17'd0}) begin failures++; $display("FAIL cg_w2_unchanged got=%h want 20000", got[2]); end
    end
    drain(); got.delete();
    cfg_write(4'd2, 17'd2, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL cg_idle_ok got=%b want 0", e); end
    send(17'd5, 1'b0); send(17'd0, 1'b0); send(17'd0, 1'b1);
    wait_outputs(3);
    checks++; if (got.size() != 3) begin failures++; $display("FAIL cg_new_count got=%0d want 3", got.size()); end
    else begin
      checks++; if (got[0] !== {1'b0, 17'd5}) begin failures++; $display("FAIL cg_new0 got=%h want 5", got[0]); end
      checks++; if (got[2] !== {1'b1, 17'd10}) begin failures++; $display("FAIL cg_new2 got=%h want 2000a", got[2]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [17:0] exp [3] = '{{1'b0, 17'd11}, {1'b0, 17'd22}, {1'b1, 17'd33}};
    set_weights(17'd1, 17'd0, 17'd0, 17'd0, 17'd0);
    m_ready = 1'b0; got.delete();
    for (int i = 1; i <= 7; i++) send(17'(i), 1'b0);
    tick(); tick();
    checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rm_pre_state m_valid=%b busy=%b want 1/1", m_valid, busy);
    end
    rst = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rm_m_valid got=%b want 0", m_valid); end
    checks++; if (m_data !== 17'd0) begin failures++; $display("FAIL rm_m_data got=%h want 0", m_data); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rm_m_last got=%b want 0", m_last); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rm_s_ready got=%b want 0", s_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b want 0", busy); end
    rst = 1'b0; m_ready = 1'b1;
    repeat (20) tick();
    checks++; if (got.size() != 0) begin failures++; $display("FAIL rm_stale got=%0d want 0", got.size()); end
    set_weights(17'd1, 17'd0, 17'd0, 17'd0, 17'd0);
    got.delete();
    send(17'd11, 1'b0); send(17'd22, 1'b0); send(17'd33, 1'b1);
    wait_outputs(3);
    checks++; if (got.size() != 3) begin failures++; $display("FAIL rm_count got=%0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rm_out%0d got=%h want %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_boxcar();
    test_saturation();
    test_backpressure();
    test_config_guard();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
